// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and constants for the block-RAM port front-end.
// Partial-strobe read-modify-write is compiled in with MEM_PORT_CTRL_RMW_EN.
package mem_port_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RESP_W = DATA_W + 1;

  localparam logic [STRB_W-1:0] STRB_FULL = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RMW  = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  // Byte-wise select: strobed bytes come from the new data, the rest from RAM.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] wdata,
                                                    input logic [DATA_W-1:0] rdata,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < int'(STRB_W); i++) begin
      m[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Synchronous response FIFO {we, rdata}; valid is registered so RAM data never
// reaches the consumer in the same cycle it is pushed.
module mem_resp_fifo
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  resp_t                        push_data,
  input  logic                         pop,
  output logic                         out_valid,
  output resp_t                        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [RESP_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Storage needs no reset: it is only observed while valid_q is set.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_data  = resp_t'(mem_q[rd_ptr_q]);
  assign out_valid = valid_q;
  assign count     = count_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// Request/response front-end for one port of the dual-port block-RAM wrapper.
// Define MEM_PORT_CTRL_RMW_EN to honour partial byte strobes via read-modify-write.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [WIDTH-1:0]  REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [STRB_W-1:0] REQ_STRB,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic [DATA_W-1:0] RESP_RDATA,
  output logic              RESP_WE,
  output logic              RAM_RDEN,
  output logic [WIDTH-1:0]  RAM_RADDR,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              RAM_WREN,
  output logic [WIDTH-1:0]  RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA
);

  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  state_e           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic             inflight_rd_q, inflight_rd_d;
  logic             accept, pop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  resp_t            push_data, resp_out;

  // A slot is reserved for every accepted request until its response is popped.
  assign pop       = RESP_VALID & RESP_READY;
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign REQ_READY = RST && (state_q == S_IDLE) && (occupancy < (CNT_W+1)'(RESP_DEPTH));
  assign accept    = REQ_VALID & REQ_READY;

`ifdef MEM_PORT_CTRL_RMW_EN
  logic              rmw_load;
  logic              partial_wr;
  logic [WIDTH-1:0]  rmw_addr_q;
  logic [DATA_W-1:0] rmw_wdata_q;
  logic [STRB_W-1:0] rmw_strb_q;

  assign partial_wr = (REQ_STRB != STRB_FULL) && (REQ_STRB != '0);
`else
  logic unused_strb;
  assign unused_strb = ^REQ_STRB;
`endif

  always_comb begin
    state_d       = state_q;
    inflight_d    = 1'b0;
    inflight_rd_d = 1'b0;
    RAM_RDEN      = 1'b0;
    RAM_WREN      = 1'b0;
    RAM_RADDR     = REQ_ADDR;
    RAM_WADDR     = REQ_ADDR;
    RAM_WDATA     = REQ_WDATA;
`ifdef MEM_PORT_CTRL_RMW_EN
    rmw_load      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!REQ_WE) begin
            RAM_RDEN      = 1'b1;
            inflight_d    = 1'b1;
            inflight_rd_d = 1'b1;
          end
`ifdef MEM_PORT_CTRL_RMW_EN
          else if (REQ_STRB == '0) begin
            inflight_d = 1'b1;
          end else if (partial_wr) begin
            RAM_RDEN = 1'b1;
            rmw_load = 1'b1;
            state_d  = S_RMW;
          end
`endif
          else begin
            RAM_WREN   = 1'b1;
            inflight_d = 1'b1;
          end
        end
      end
      S_RMW: begin
`ifdef MEM_PORT_CTRL_RMW_EN
        RAM_WREN   = 1'b1;
        RAM_WADDR  = rmw_addr_q;
        RAM_WDATA  = merge_bytes(rmw_wdata_q, RAM_RDATA, rmw_strb_q);
        inflight_d = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      inflight_q    <= 1'b0;
      inflight_rd_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      inflight_rd_q <= inflight_rd_d;
    end
  end

`ifdef MEM_PORT_CTRL_RMW_EN
  // Partial-write request held for the merge cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_strb_q  <= '0;
    end else if (rmw_load) begin
      rmw_addr_q  <= REQ_ADDR;
      rmw_wdata_q <= REQ_WDATA;
      rmw_strb_q  <= REQ_STRB;
    end
  end
`endif

  assign push_data.we    = ~inflight_rd_q;
  assign push_data.rdata = inflight_rd_q ? RAM_RDATA : '0;

  mem_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (inflight_q),
    .push_data(push_data),
    .pop      (pop),
    .out_valid(RESP_VALID),
    .out_data (resp_out),
    .count    (fifo_count)
  );

  assign RESP_RDATA = resp_out.rdata;
  assign RESP_WE    = resp_out.we;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl with a behavioural 1-cycle-latency block RAM.
module tb_mem_port_ctrl;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic              REQ_WE = 1'b0;
  logic [WIDTH-1:0]  REQ_ADDR = '0;
  logic [31:0]       REQ_WDATA = '0;
  logic [3:0]        REQ_STRB = 4'hF;
  logic              RESP_VALID;
  logic              RESP_READY = 1'b1;
  logic [31:0]       RESP_RDATA;
  logic              RESP_WE;
  logic              RAM_RDEN;
  logic [WIDTH-1:0]  RAM_RADDR;
  logic [31:0]       RAM_RDATA;
  logic              RAM_WREN;
  logic [WIDTH-1:0]  RAM_WADDR;
  logic [31:0]       RAM_WDATA;

  typedef struct {
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pops     = 0;
  logic [31:0] ram [1024];

`ifdef MEM_PORT_CTRL_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  mem_port_ctrl #(.WIDTH(WIDTH), .RESP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_RDATA(RESP_RDATA), .RESP_WE(RESP_WE),
    .RAM_RDEN(RAM_RDEN), .RAM_RADDR(RAM_RADDR), .RAM_RDATA(RAM_RDATA),
    .RAM_WREN(RAM_WREN), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA)
  );

  always #5 CLK = ~CLK;

  // Block RAM: read data registered one cycle after RDEN, read-before-write.
  always @(posedge CLK) begin
    if (RAM_RDEN) RAM_RDATA <= ram[RAM_RADDR];
    if (RAM_WREN) ram[RAM_WADDR] <= RAM_WDATA;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop-and-compare on every consumed response, plus hold and overlap checks.
  logic        hold = 1'b0;
  logic        hold_we;
  logic [31:0] hold_data;
  always @(negedge CLK) begin
    if (RST) begin
      check("rden_wren_overlap", 32'(RAM_RDEN & RAM_WREN), 32'd0);
      if (hold) begin
        check("hold_valid", 32'(RESP_VALID), 32'd1);
        check("hold_rdata", RESP_RDATA, hold_data);
        check("hold_we", 32'(RESP_WE), 32'(hold_we));
      end
      if (RESP_VALID && RESP_READY) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(RESP_VALID), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_we", 32'(RESP_WE), 32'(e.we));
          check("resp_rdata", RESP_RDATA, e.data);
        end
      end
      hold      = RESP_VALID && !RESP_READY;
      hold_we   = RESP_WE;
      hold_data = RESP_RDATA;
    end else begin
      hold = 1'b0;
    end
  end

  task automatic send(input logic we, input logic [WIDTH-1:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_data, output int waits);
    exp_t e;
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    REQ_STRB  = strb;
    waits     = 0;
    forever begin
      @(negedge CLK);
      if (REQ_READY) break;
      waits++;
      if (waits > 20) begin
        check("accept_timeout", 32'(REQ_READY), 32'd1);
        REQ_VALID = 1'b0;
        waits = -1;
        return;
      end
    end
    e.we   = we;
    e.data = exp_data;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic ack_latency(output int k);
    k = 0;
    while (!RESP_VALID && k < 10) begin
      @(posedge CLK);
      #1;
      k++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, k, p0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    for (int i = 0; i < 8; i++) ram[16+i] = 32'hA5A5_0000 | 32'(i);
    for (int i = 0; i < 4; i++) ram[32+i] = 32'h5A5A_0000 | 32'(i);
    ram[5] = 32'h1122_3344;
    ram[6] = 32'h0000_0066;
    ram[7] = 32'h0123_4567;

    // Reset values
    #12;
    check("rst_resp_valid", 32'(RESP_VALID), 32'd0);
    check("rst_req_ready", 32'(REQ_READY), 32'd0);
    check("rst_rden", 32'(RAM_RDEN), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("post_rst_ready", 32'(REQ_READY), 32'd1);

    // Reset asserted while a read is being accepted
    idle(1);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 10'd1;
    @(negedge CLK);
    check("midread_rden", 32'(RAM_RDEN), 32'd1);
    #1 RST = 1'b0;
    #1;
    check("midread_rst_rden", 32'(RAM_RDEN), 32'd0);
    check("midread_rst_ready", 32'(REQ_READY), 32'd0);
    check("midread_rst_valid", 32'(RESP_VALID), 32'd0);
    REQ_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rerelease_ready", 32'(REQ_READY), 32'd1);
    idle(3);
    check("rerelease_no_resp", 32'(RESP_VALID), 32'd0);

    // Write then read of the same address on the next cycle
    send(1'b1, 10'd3, 32'hDEAD_BEEF, 4'hF, 32'h0, w);
    check("raw_wr_wait", 32'(w), 32'd0);
    send(1'b0, 10'd3, 32'h0, 4'hF, 32'hDEAD_BEEF, w);
    check("raw_rd_wait", 32'(w), 32'd0);
    idle(4);
    check("raw_drained", 32'(exp_q.size()), 32'd0);

    // Streaming reads: one accept and one response per cycle
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 10'(16 + i), 32'h0, 4'hF, 32'hA5A5_0000 | 32'(i), w);
      check("stream_ready", 32'(w), 32'd0);
    end
    idle(3);
    check("stream_pops", 32'(pops - p0), 32'd8);

    // Backpressure: FIFO plus in-flight slots fill, then drain in order
    RESP_READY = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      send(1'b0, 10'(32 + i), 32'h0, 4'hF, 32'h5A5A_0000 | 32'(i), w);
      check("bp_fill_wait", 32'(w), 32'd0);
    end
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 10'(32 + DEPTH);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_ready_low", 32'(REQ_READY), 32'd0);
    end
    @(posedge CLK);
    #1 RESP_READY = 1'b1;
    send(1'b0, 10'(32 + DEPTH), 32'h0, 4'hF, 32'h5A5A_0000 | 32'(DEPTH), w);
    check("bp_release_wait", 32'(w), 32'd0);
    send(1'b0, 10'(33 + DEPTH), 32'h0, 4'hF, 32'h5A5A_0000 | 32'(DEPTH + 1), w);
    idle(4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Partial-strobe write: merged under RMW, full-word otherwise
    send(1'b1, 10'd5, 32'hAABB_CCDD, 4'b0101, 32'h0, w);
    ack_latency(k);
    check("strb_ack_latency", 32'(k), RMW ? 32'd2 : 32'd1);
    idle(2);
    check("strb_mem5", ram[5], RMW ? 32'h11BB_33DD : 32'hAABB_CCDD);

    // Zero-strobe write: no RAM change under RMW
    send(1'b1, 10'd6, 32'h0000_0055, 4'b0000, 32'h0, w);
    ack_latency(k);
    check("zstrb_ack_latency", 32'(k), 32'd1);
    idle(2);
    check("zstrb_mem6", ram[6], RMW ? 32'h0000_0066 : 32'h0000_0055);

    // Partial write immediately followed by a read of the same word
    send(1'b1, 10'd7, 32'hFFEE_DDCC, 4'b1010, 32'h0, w);
    send(1'b0, 10'd7, 32'h0, 4'hF, RMW ? 32'hFF23_DD67 : 32'hFFEE_DDCC, w);
    check("rmw_rd_wait", 32'(w), RMW ? 32'd1 : 32'd0);
    idle(5);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
